demux_1n_stream: RTL
====================

DEMUX_1N_STREAM -- requirements
Module: demux_1n_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width in bits.
REQ-002 SHALL have parameter N, default 2, number of output channels (N >= 2).
REQ-003 SHALL have derived localparam SELW = max(1, clog2(N)), select width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  WIDTH  payload to route.
REQ-007 SHALL have port in_sel  input  SELW  destination channel index (unicast).
REQ-008 SHALL have port in_bcast  input  1  1 = broadcast to all channels; in_sel ignored.
REQ-009 SHALL have port in_valid  input  1  source offers a word.
REQ-010 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-011 SHALL have port out_data  output  N*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid  output  N  channel k holds a word.
REQ-013 SHALL have port out_ready  input  N  sink k consumes the word this cycle.
REQ-014 SHALL have port err  output  1  one-cycle pulse: word accepted with out-of-range in_sel.

Function
REQ-015 SHALL keep one holding register (valid bit + WIDTH data) per channel; out_valid/out_data are driven directly from these registers.
REQ-016 SHALL define free[k] = !out_valid[k] | out_ready[k].
REQ-017 SHALL drive in_ready combinationally: rst -> 0; in_bcast=1 -> AND of free[0..N-1]; in_sel<N -> free[in_sel]; in_sel>=N -> 1.
REQ-018 SHALL define transfer = in_valid & in_ready; no state changes on the input side without transfer.
REQ-019 SHALL, on a unicast transfer with in_sel<N, load in_data into channel in_sel: out_valid set and out_data updated on the next edge (latency 1 cycle).
REQ-020 SHALL, on a broadcast transfer, load in_data into all N channels on the same edge.
REQ-021 SHALL, on a unicast transfer with in_sel>=N, discard the word, leave all channels unchanged, and assert err for exactly the following cycle.
REQ-022 SHALL clear out_valid[k] on an edge where out_valid[k]=1, out_ready[k]=1 and channel k is not loaded.
REQ-023 SHALL, on simultaneous drain and load of channel k, keep out_valid[k]=1 and replace out_data with the new word (no bubble).
REQ-024 SHALL hold out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-025 SHALL sustain one accepted word per cycle when destination sinks hold out_ready=1.
REQ-026 SHALL drain channels independently; a stalled channel SHALL NOT block unicast traffic to other channels.
REQ-027 SHALL ignore out_ready[k] when out_valid[k]=0.
REQ-028 SHALL neither drop nor duplicate a word except the REQ-021 discard.

Reset
REQ-029 SHALL, while rst=1 at an edge, clear all out_valid to 0, all out_data to 0 and err to 0.
REQ-030 SHALL force in_ready=0 while rst=1; in_valid during reset is not accepted.
REQ-031 SHALL discard held words on reset mid-operation; first accept possible in the cycle after rst falls.

Verification (WIDTH=4, N=3, SELW=2)
REQ-032 SHALL cover reset: rst=1 two cycles, in_valid=1 -> in_ready=0, out_valid=000, out_data=0, err=0.
REQ-033 SHALL cover unicast: in_data=0xA, in_sel=1, out_ready=111 -> next cycle out_valid=010, ch1 data 0xA; words 0x0..0xF to sel 0,1,2 cyclically -> one accept per cycle, each on the right channel.
REQ-034 SHALL cover backpressure: out_ready[0]=0, send 0x5 then 0x6 to ch0 -> 0x5 held stable, in_ready=0 for 0x6; a word to ch2 meanwhile accepted; raise out_ready[0] -> 0x6 appears next cycle.
REQ-035 SHALL cover broadcast: ch2 holds a word with out_ready[2]=0, in_bcast=1, in_data=0xC -> in_ready=0; raise out_ready[2] -> accept, next cycle out_valid=111, all channels 0xC.
REQ-036 SHALL cover out-of-range: in_sel=3, in_data=0x9 -> in_ready=1, err=1 for one cycle, out_valid unchanged.
REQ-037 SHALL cover reset mid-operation: channels 0,1 holding with out_ready=00, assert rst one cycle -> out_valid=000, out_data=0.

Source files
------------

// File: rtl/demux_1n_stream.sv
// 1-to-N stream demultiplexer with one holding register per output channel.
// Supports unicast by index, broadcast to all channels, and an error pulse when a word is sent to a missing channel.
module demux_1n_stream #(
  parameter  int WIDTH = 4,
  parameter  int N     = 2,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic                 err
);

  logic [N-1:0] free;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         transfer;

  assign free     = ~out_valid | out_ready;
  assign sel_ok   = 32'(in_sel) < 32'(N);
  assign transfer = in_valid & in_ready;

  // A word for a channel that does not exist is always accepted so it can be dropped and flagged.
  always_comb begin
    in_ready = 1'b0;
    if (rst)
      in_ready = 1'b0;
    else if (in_bcast)
      in_ready = &free;
    else if (sel_ok)
      in_ready = free[in_sel];
    else
      in_ready = 1'b1;
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++)
      load[k] = transfer & (in_bcast | (sel_ok & (32'(in_sel) == 32'(k))));
  end

  // A load takes priority over a drain on the same channel, so back-to-back words leave no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      err <= transfer & ~in_bcast & ~sel_ok;
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          out_valid[k]               <= 1'b1;
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule
